// File: rtl/core_pkg.sv
// Shared constants and FSM state type for the sequential RV32M multiply/divide unit.
package core_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/core_muldiv_seq.sv
// Iterative RV32M unit: one shift-add or restoring-divide step per cycle on operand
// magnitudes, sign-corrected at the end, with one-cycle shortcuts for the divide corner cases.
module core_muldiv_seq
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [6:0]      i_opcode,
  input  logic [6:0]      i_funct7,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_dout,
  input  logic [XLEN-1:0] i_rs2_dout,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  state_t state, state_next;

  logic            m_req, accept, fast_path;
  logic            a_signed_in, b_signed_in, sign_a_in, sign_b_in;
  logic            div_zero_in, overflow_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in, fast_result;

  logic [CW-1:0]   count;
  logic [2:0]      f3_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] acc_q, lo_q, opb_q, result_q;

  logic            is_div_q, add_sub, quot_bit;
  logic [XLEN:0]   add_a, add_b, add_sum;
  logic [XLEN-1:0] acc_step, lo_step, final_result;
  logic [2*XLEN-1:0] prod, prod_signed;

  assign m_req  = (i_opcode == OPCODE_R) && (i_funct7 == FUNCT7_MULDIV);
  assign accept = (state == IDLE) && m_req && !i_flush;

  // Operand decode: which inputs are signed for this funct3, and their magnitudes.
  assign a_signed_in = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                       (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
  assign b_signed_in = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign sign_a_in   = a_signed_in && i_rs1_dout[XLEN-1];
  assign sign_b_in   = b_signed_in && i_rs2_dout[XLEN-1];
  assign mag_a_in    = sign_a_in ? negate(i_rs1_dout) : i_rs1_dout;
  assign mag_b_in    = sign_b_in ? negate(i_rs2_dout) : i_rs2_dout;

  assign div_zero_in = i_funct3[2] && (i_rs2_dout == '0);
  assign overflow_in = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                       (i_rs1_dout == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_dout == '1);
  assign fast_path   = div_zero_in || overflow_in;

  // funct3[1] separates the remainder flavours from the quotient flavours.
  always_comb begin
    fast_result = '0;
    if (div_zero_in) begin
      fast_result = i_funct3[1] ? i_rs1_dout : '1;
    end else if (overflow_in) begin
      fast_result = i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (m_req) state_next = fast_path ? DONE : CALC;
        CALC:    if (count == CW'(1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_stall = 1'b0;
    o_done  = 1'b0;
    case (state)
      IDLE:    o_stall = m_req;
      CALC:    o_stall = 1'b1;
      DONE:    o_done  = !i_flush;
      default: ;
    endcase
  end

  assign o_result = result_q;

  // The one shared XLEN+1-bit adder: accumulate for multiply, trial subtract for divide.
  assign is_div_q = f3_q[2];

  always_comb begin
    if (is_div_q) begin
      add_a   = {acc_q, lo_q[XLEN-1]};
      add_b   = {1'b0, opb_q};
      add_sub = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q};
      add_b   = lo_q[0] ? {1'b0, opb_q} : '0;
      add_sub = 1'b0;
    end
  end

  assign add_sum = add_a + (add_sub ? ~add_b : add_b) + (XLEN+1)'(add_sub);

  // The partial remainder stays below the divisor, so the top sum bit is a clean borrow flag.
  always_comb begin
    quot_bit = 1'b0;
    if (is_div_q) begin
      quot_bit = ~add_sum[XLEN];
      acc_step = quot_bit ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
      lo_step  = {lo_q[XLEN-2:0], quot_bit};
    end else begin
      acc_step = add_sum[XLEN:1];
      lo_step  = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod        = {acc_step, lo_step};
  assign prod_signed = (sign_a_q ^ sign_b_q) ? (~prod + (2*XLEN)'(1)) : prod;

  always_comb begin
    case (f3_q)
      F3_MUL:                         final_result = prod_signed[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   final_result = prod_signed[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                final_result = (sign_a_q ^ sign_b_q) ? negate(lo_step) : lo_step;
      F3_REM, F3_REMU:                final_result = sign_a_q ? negate(acc_step) : acc_step;
      default:                        final_result = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      count    <= CW'(XLEN);
      f3_q     <= i_funct3;
      sign_a_q <= sign_a_in;
      sign_b_q <= sign_b_in;
      acc_q    <= '0;
      lo_q     <= mag_a_in;
      opb_q    <= mag_b_in;
      if (fast_path) result_q <= fast_result;
    end else if ((state == CALC) && !i_flush) begin
      acc_q <= acc_step;
      lo_q  <= lo_step;
      count <= count - CW'(1);
      if (count == CW'(1)) result_q <= final_result;
    end
  end

endmodule

// File: tb/tb_core_muldiv_seq.sv
// Randomised and directed checks of core_muldiv_seq against a plain-arithmetic RV32M model.
module tb_core_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  core_muldiv_seq #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct7(funct7),
    .i_funct3(funct3), .i_rs1_dout(rs1), .i_rs2_dout(rs2), .i_flush(flush),
    .o_stall(stall), .o_done(done), .o_result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        q = sa / sb; p = 64'(q); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; p = 64'(q); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; p = 64'(q); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; p = 64'(q); return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 >= 3'd4 && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one M-op starting just after a rising edge and follows it through to its result.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] expected;
    int lat, cyc;
    logic seen, stall_ok;
    expected = ref_model(f3, a, b);
    lat      = ref_latency(f3, a, b);
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = f3; rs1 = a; rs2 = b;
    #1;
    checkOutput({tag, " stall_at_accept"}, 32'(stall), 32'd1);
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (!stall) stall_ok = 1'b0;
    end
    checkOutput({tag, " latency"}, 32'(cyc), 32'(lat));
    checkOutput({tag, " result"}, result, expected);
    checkOutput({tag, " stall_during_calc"}, 32'(stall_ok), 32'd1);
    checkOutput({tag, " stall_in_done"}, 32'(stall), 32'd0);
    opcode = '0; funct7 = '0;
    @(posedge clk); #1;
    checkOutput({tag, " done_pulse_width"}, 32'(done), 32'd0);
  endtask

  task automatic watchNoDone(input int cycles, input string tag);
    logic any_done;
    any_done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) any_done = 1'b1;
    end
    checkOutput(tag, 32'(any_done), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand(input int sel);
    case (sel)
      0: return 32'd0;
      1: return MIN_INT;
      2: return 32'hFFFF_FFFF;
      3: return 32'(($urandom_range(0, 15)));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    #12;
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain R-type with funct7=0 is not an M-op.
    opcode = 7'b0110011; funct7 = 7'b0000000; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
    #1;
    checkOutput("non_mop stall", 32'(stall), 32'd0);
    watchNoDone(5, "non_mop no_done");
    opcode = '0;

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_neg3");
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_neg1_2");
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_neg1_neg1");
    applyStimulus(3'd5, 32'd100, 32'd0, "divu_by_zero");
    applyStimulus(3'd7, 32'd100, 32'd0, "remu_by_zero");
    applyStimulus(3'd4, 32'd100, 32'd0, "div_by_zero");
    applyStimulus(3'd6, 32'hFFFF_FFF0, 32'd0, "rem_by_zero");
    applyStimulus(3'd4, MIN_INT, 32'hFFFF_FFFF, "div_overflow");
    applyStimulus(3'd6, MIN_INT, 32'hFFFF_FFFF, "rem_overflow");
    applyStimulus(3'd5, MIN_INT, 32'hFFFF_FFFF, "divu_min_max");
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg7_2");
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    applyStimulus(3'd4, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    applyStimulus(3'd6, 32'd7, 32'hFFFF_FFFE, "rem_7_neg2");

    // Flush on the tenth CALC cycle.
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = 3'd0; rs1 = 32'd1234; rs2 = 32'd5678;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; opcode = '0; funct7 = '0;
    @(posedge clk); #1;
    checkOutput("flush done_suppressed", 32'(done), 32'd0);
    checkOutput("flush idle_no_stall", 32'(stall), 32'd0);
    flush = 1'b0;
    watchNoDone(40, "flush no_late_done");
    applyStimulus(3'd0, 32'd3, 32'd4, "mul_after_flush");

    // Reset asserted in the middle of CALC.
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = 3'd5; rs1 = 32'd999; rs2 = 32'd7;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; opcode = '0; funct7 = '0;
    #2;
    checkOutput("midcalc_reset stall", 32'(stall), 32'd0);
    checkOutput("midcalc_reset result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    watchNoDone(40, "midcalc_reset no_done");

    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick_operand(int'($urandom_range(0, 7)));
      rb  = pick_operand(int'($urandom_range(0, 7)));
      applyStimulus(rf3, ra, rb, $sformatf("rand%0d_f3_%0d", n, rf3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_muldiv_seq.md
CORE_MULDIV_SEQ -- requirements
Module: core_muldiv_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and operand width.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_opcode, input, 7, the opcode of the EX-stage instruction.
REQ-005 The block SHALL have port i_funct7, input, 7, the funct7 of the EX-stage instruction.
REQ-006 The block SHALL have port i_funct3, input, 3, the RV32M operation select (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-007 The block SHALL have port i_rs1_dout, input, XLEN, the forwarded rs1 operand.
REQ-008 The block SHALL have port i_rs2_dout, input, XLEN, the forwarded rs2 operand.
REQ-009 The block SHALL have port i_flush, input, 1, the branch-taken pipeline kill.
REQ-010 The block SHALL have port o_stall, output, 1, the request to hold IF/ID/EX.
REQ-011 The block SHALL have port o_done, output, 1, a one-cycle result-valid pulse.
REQ-012 The block SHALL have port o_result, output, XLEN, the rd write data, valid only while o_done=1.

Function
REQ-013 The block SHALL treat the instruction as an M-op (m_req) when i_opcode=7'b0110011 and i_funct7=7'b0000001.
REQ-014 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 The block SHALL transition IDLE->CALC on m_req with no fast-path case, latching operands, funct3 and operand signs, and loading the iteration counter with XLEN.
REQ-016 The block SHALL perform one shift-add (multiply) or one restoring-divide step on operand magnitudes per CALC cycle, decrement the counter, and transition to DONE when the counter reaches 1.
REQ-017 The block SHALL, in DONE, assert o_done=1 and o_stall=0, drive the sign-corrected o_result, and return to IDLE unconditionally; it SHALL NOT accept a new m_req in DONE.
REQ-018 The block SHALL produce o_done exactly XLEN+1 cycles after acceptance (33 at XLEN=32).
REQ-019 The block SHALL drive o_stall = m_req in IDLE, 1 in CALC, and 0 in DONE.
REQ-020 The block SHALL go IDLE->DONE in 1 cycle for divide-by-zero: DIV/DIVU quotient = all ones, REM/REMU result = rs1.
REQ-021 The block SHALL go IDLE->DONE in 1 cycle for signed overflow, DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-022 The block SHALL apply these sign rules: MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product; the quotient is negated when operand signs differ; the remainder takes the dividend's sign.
REQ-023 The block SHALL, on i_flush=1 in any state, enter IDLE next cycle with o_done suppressed; i_flush has priority over m_req.

Reset
REQ-024 The block SHALL, while i_rst_n=0, hold the state at IDLE, zero the counter, operand, accumulator and result registers, and drive o_stall=0, o_done=0 and o_result=0.
REQ-025 The block SHALL abort any operation in progress on reset assertion mid-CALC, with no o_done pulse after release.

Structure
REQ-026 Package core_pkg SHALL hold OPCODE_R, FUNCT7_MULDIV, the funct3 encodings and the FSM state enum.
REQ-027 The design SHALL be a single module with no sub-module; the shift-add and divide steps share one XLEN+1-bit adder/subtractor.

Verification
REQ-028 The bench SHALL apply MUL 7 x 0xFFFFFFFD and check o_result=0xFFFFFFEB with o_done 33 cycles after acceptance and o_stall high throughout.
REQ-029 The bench SHALL apply MULHU 0xFFFFFFFF x 0xFFFFFFFF and check o_result=0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-030 The bench SHALL apply DIVU 100/0 and check 0xFFFFFFFF, and REMU 100/0 and check 100, each with o_done one cycle after acceptance.
REQ-031 The bench SHALL apply DIV 0x80000000/0xFFFFFFFF and check 0x80000000 in 1 cycle; REM gives 0.
REQ-032 The bench SHALL apply REM 0xFFFFFFF9/2 and check 0xFFFFFFFF; DIV gives 0xFFFFFFFD.
REQ-033 The bench SHALL apply i_flush at CALC cycle 10 and check no o_done, IDLE next cycle, and that a following MUL 3x4 returns 12 normally.
